// File: rtl/viterbi_pkg.sv
// Shared types and constant helpers for the parametrised rate-1/2 Viterbi decoder.
// Holds the block-state enum, the encoder code-symbol function and the metric init value.
package viterbi_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    INIT  = 2'd2
  } vit_state_e;

  // Encoder register is {state, u}; bit 0 of each generator taps the newest input.
  function automatic logic [1:0] code_sym(input int state, input int u, input int g0,
                                          input int g1, input int k);
    int r;
    r = ((state << 1) | u) & ((1 << k) - 1);
    return {^(r & g1), ^(r & g0)};
  endfunction

  function automatic logic [31:0] pm_init(input int s, input int pmw);
    return (s == 0) ? 32'd0 : (32'd1 << (pmw - 2));
  endfunction

endpackage

// File: rtl/viterbi_param_if.sv
// Symbol-in / decision-out bundle between the metric stage, the decoder and the decision logic.
interface viterbi_param_if #(
  parameter int BMW = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [4*BMW-1:0] bm;
  logic             flush;
  logic             out_valid;
  logic             out;
  logic             error;

  modport master (output in_valid, bm, flush, input in_ready, out_valid, out, error);
  modport slave  (input in_valid, bm, flush, output in_ready, out_valid, out, error);
endinterface

// File: rtl/viterbi_acs_unit.sv
// One add-compare-select for a single next state: two candidate sums, ties resolved to b=0.
module viterbi_acs_unit #(
  parameter int PMW = 8,
  parameter int BMW = 3
) (
  input  logic [PMW-1:0] i_pm0,
  input  logic [PMW-1:0] i_pm1,
  input  logic [BMW-1:0] i_bm0,
  input  logic [BMW-1:0] i_bm1,
  output logic [PMW:0]   o_metric,
  output logic           o_sel
);
  logic [PMW:0] w_cand0;
  logic [PMW:0] w_cand1;

  assign w_cand0  = {1'b0, i_pm0} + {{(PMW + 1 - BMW){1'b0}}, i_bm0};
  assign w_cand1  = {1'b0, i_pm1} + {{(PMW + 1 - BMW){1'b0}}, i_bm1};
  assign o_sel    = (w_cand1 < w_cand0);
  assign o_metric = o_sel ? w_cand1 : w_cand0;
endmodule

// File: rtl/viterbi_param.sv
// Parametrised Viterbi decoder: parallel ACS, per-step metric normalisation,
// register-exchange survivors of depth TB, and a flush/init sequence per block.
module viterbi_param
  import viterbi_pkg::*;
#(
  parameter int           K   = 3,
  parameter logic [K-1:0] G0  = 3'b111,
  parameter logic [K-1:0] G1  = 3'b101,
  parameter int           BMW = 3,
  parameter int           PMW = 8,
  parameter int           TB  = 12
) (
  input logic             clk,
  input logic             reset,
  viterbi_param_if.slave  bus
);
  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int FW = $clog2(TB + 1);

  generate
    if (PMW < BMW + K + 1) begin : g_pmw_chk
      $error("viterbi_param: PMW must be at least BMW+K+1");
    end
    if (K < 3 || K > 7) begin : g_k_chk
      $error("viterbi_param: K must lie in 3..7");
    end
    if (TB < K) begin : g_tb_chk
      $error("viterbi_param: TB must be at least K");
    end
  endgenerate

  logic [PMW-1:0] r_pm [NS];
  logic [TB-1:0]  r_sv [NS];
  logic [FW-1:0]  r_fill;
  logic [FW-1:0]  r_drain;
  logic [TB-1:0]  r_flush_sv;
  logic [SW-1:0]  r_best;
  vit_state_e     r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_out;
  logic           r_error;

  logic [PMW:0]   w_new [NS];
  logic [PMW-1:0] w_norm [NS];
  logic [TB-1:0]  w_sv_next [NS];
  logic [NS-1:0]  w_sel;
  logic [PMW:0]   w_min;
  logic [SW-1:0]  w_best;
  logic           w_dec;
  logic           w_err;
  logic           w_acc;
  logic           w_emit;
  logic [FW-1:0]  w_fill_inc;
  logic [FW-1:0]  w_fill_after;
  logic [FW-1:0]  w_drain;
  logic [TB-1:0]  w_flush_src;
  logic [TB-1:0]  w_flush_aligned;

  // Predecessors of state g are {b, g[K-2:1]}; the input bit that led here is g[0].
  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam int   P0 = g >> 1;
    localparam int   P1 = (g >> 1) | (NS >> 1);
    localparam logic U  = 1'(g % 2);
    localparam int   B0 = int'(code_sym(P0, g % 2, int'(G0), int'(G1), K)) * BMW;
    localparam int   B1 = int'(code_sym(P1, g % 2, int'(G0), int'(G1), K)) * BMW;

    viterbi_acs_unit #(.PMW(PMW), .BMW(BMW)) u_acs (
      .i_pm0    (r_pm[P0]),
      .i_pm1    (r_pm[P1]),
      .i_bm0    (bus.bm[B0 +: BMW]),
      .i_bm1    (bus.bm[B1 +: BMW]),
      .o_metric (w_new[g]),
      .o_sel    (w_sel[g])
    );

    assign w_norm[g]    = PMW'(w_new[g] - w_min);
    assign w_sv_next[g] = w_sel[g] ? {r_sv[P1][TB-2:0], U} : {r_sv[P0][TB-2:0], U};
  end

  // Minimum new metric and the lowest-index state achieving it
  always_comb begin
    logic lt;
    w_min  = w_new[0];
    w_best = '0;
    lt     = 1'b0;
    for (int i = 1; i < NS; i++) begin
      lt     = (w_new[i] < w_min);
      w_best = lt ? SW'(i) : w_best;
      w_min  = lt ? w_new[i] : w_min;
    end
  end

  // Decision bit of the best survivor and the merge check across all survivors
  always_comb begin
    w_dec = w_sv_next[w_best][TB-1];
    w_err = 1'b0;
    for (int i = 1; i < NS; i++) begin
      w_err = w_err | (w_sv_next[i][TB-1] ^ w_sv_next[0][TB-1]);
    end
  end

  // Handshake, fill bookkeeping and flush alignment; the drained bits are moved up to TB-1
  always_comb begin
    w_acc           = bus.in_valid && r_in_ready && (r_state == RUN);
    w_emit          = w_acc && (r_fill >= FW'(TB - 1));
    w_fill_inc      = (r_fill == FW'(TB)) ? r_fill : r_fill + FW'(1);
    w_fill_after    = w_acc ? w_fill_inc : r_fill;
    w_drain         = (w_fill_after > FW'(TB - 1)) ? FW'(TB - 1) : w_fill_after;
    w_flush_src     = w_acc ? w_sv_next[w_best] : r_sv[r_best];
    w_flush_aligned = w_flush_src << (FW'(TB) - w_drain);
  end

  // Trellis step, survivor update and block FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        r_pm[i] <= PMW'(pm_init(i, PMW));
        r_sv[i] <= '0;
      end
      r_fill      <= '0;
      r_drain     <= '0;
      r_flush_sv  <= '0;
      r_best      <= '0;
      r_state     <= RUN;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_acc) begin
            for (int i = 0; i < NS; i++) begin
              r_pm[i] <= w_norm[i];
              r_sv[i] <= w_sv_next[i];
            end
            r_best <= w_best;
            r_fill <= w_fill_inc;
          end
          r_out_valid <= w_emit;
          if (w_emit) begin
            r_out   <= w_dec;
            r_error <= w_err;
          end
          if (bus.flush) begin
            r_in_ready <= 1'b0;
            r_drain    <= w_drain;
            r_flush_sv <= w_flush_aligned;
            r_state    <= (w_drain == '0) ? INIT : FLUSH;
          end
        end
        FLUSH: begin
          r_out_valid <= 1'b1;
          r_out       <= r_flush_sv[TB-1];
          r_error     <= 1'b0;
          r_flush_sv  <= r_flush_sv << 1;
          r_drain     <= r_drain - FW'(1);
          if (r_drain <= FW'(1)) begin
            r_state <= INIT;
          end
        end
        INIT: begin
          for (int i = 0; i < NS; i++) begin
            r_pm[i] <= PMW'(pm_init(i, PMW));
            r_sv[i] <= '0;
          end
          r_fill      <= '0;
          r_best      <= '0;
          r_out_valid <= 1'b0;
          r_error     <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= RUN;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_state     <= INIT;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.error     = r_error;
endmodule

// File: doc/viterbi_param.md
# viterbi_param

Parametrised hard/soft-decision Viterbi decoder core for rate-1/2 feed-forward convolutional codes. It generalises the fixed 4-state decoder: the state count follows the constraint length, the generators are parameters, and metric and survivor depth are configurable. It adds a symbol-valid/ready handshake, per-step metric normalisation, register-exchange survivors of depth TB, a flush mode that drains the tail, and a merge-error flag. Branch metrics come from the upstream subset/metric stage; decoded bits go to the output decision logic.

## Interface
- K, 3: constraint length; NS = 2^(K-1) states, legal range 3..7.
- G0, 3'b111: generator for code bit c0, K bits; bit 0 taps the newest input.
- G1, 3'b101: generator for code bit c1.
- BMW, 3: branch metric width.
- PMW, 8: path metric width; elaboration error if PMW < BMW+K+1.
- TB, 12: survivor (traceback) depth, at least K.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  branch-metric vector valid.
- in_ready  output  1  decoder accepts a symbol this cycle.
- bm  input  4*BMW  packed metrics; slice i = cost of received pair vs code symbol i = {c1,c0}.
- flush  input  1  end of block; drain the remaining decided bits.
- out_valid  output  1  out and error valid.
- out  output  1  decided information bit.
- error  output  1  survivors not merged at the decision point.

## Operation
- **Trellis**
  - State s = last K-1 inputs, newest in LSB.
  - Encoder register r = {s,u}; cj = ^(r & Gj); next state ns = {s[K-3:0],u}.
  - Predecessors of ns: p_b = {b, ns[K-2:1]} for b in {0,1}; u = ns[0].
- **ACS** (on each accepted symbol, all NS states in parallel)
  - cand_b = pm[p_b] + bm[c(p_b,u)], computed at PMW+1 bits.
  - New metric is min(cand_0, cand_1); on a tie, b=0 wins.
- **Normalisation**
  - Compute the minimum of the new metrics; best = lowest index achieving it.
  - Store pm[ns] = new - min, so pm[best] = 0 after every step. No saturation is needed.
- **Survivors**
  - sv[ns] (TB bits) = {sv[p_sel][TB-2:0], u}.
  - Bit 0 is the newest decision.
- **Counter**
  - fill counts accepted symbols since reset/flush and saturates at TB.
- **FSM**
  - RUN: in_ready=1. Handshake is in_valid & in_ready.
    - Once fill ≥ TB-1, each acceptance produces one output: out = sv[best][TB-1] of the updated survivors.
    - flush (with or without a same-cycle symbol) sets drain = min(fill_after, TB-1) and goes to FLUSH. The same-cycle symbol is accepted first.
  - FLUSH: in_ready=0, in_valid ignored.
    - Each cycle emits the next-older-to-newer bit of the best-state survivor latched at flush entry; drain decrements.
    - When drain reaches 0, go to INIT. If drain=0 on entry, go straight to INIT.
  - INIT (one cycle): in_ready=0; pm[0]=0, other states 2^(PMW-2); sv=0; fill=0; then RUN.
- **error**
  - Registered alongside out.
  - RUN: 1 when bit TB-1 is not identical across all sv[].
  - FLUSH: 0.
- **Reset** gives the same metric/survivor contents as INIT.
  - State = RUN.
  - Reset values: in_ready=1, out_valid=0, out=0, error=0.
  - Reset mid-flush discards the drain.

## Timing
- ACS, normalisation and survivor update complete in one cycle; at most one symbol per clock.
- out/out_valid/error are registered: asserted the cycle after the accepting edge.
- Symbol n (0-based) is decided on acceptance of symbol n+TB-1.
- Flush output runs in consecutive cycles with no gaps. Total outputs per block = symbols accepted.
- Throughput:
  - one symbol per cycle in RUN;
  - TB-1 drain cycles plus 1 INIT cycle per block.
- in_ready is registered from the FSM state and never depends combinationally on in_valid.

## Structure
- Package viterbi_pkg holds:
  - state enum {RUN, FLUSH, INIT};
  - the function code_sym(state, u, G0, G1, K), returning the 2-bit code symbol;
  - the metric-init constant function.
- One sub-module, viterbi_acs_unit: a single ACS butterfly half with two candidate adds, compare with tie to b=0, and a select output. It is instantiated NS times via generate.
- Normalisation min-tree, survivor array and FSM stay in the top.

## Test plan
- **Clean stream**: K=3, G=111/101, hard metrics (Hamming distance × 3).
  - Stimulus: encode 1,0,1,1,0,0,1 plus K-1 zeros, then flush.
  - Required: out sequence is 1,0,1,1,0,0,1,0,0, error=0 throughout, pm[0] stays 0.
- **Correctable error**: same stream with c0 of symbol 2 inverted.
  - Required: identical decoded bits.
- **Flush boundaries**:
  - Flush after 3 symbols (fewer than TB-1) → exactly 3 out_valid pulses, then in_ready low for 4 cycles total (3 FLUSH + 1 INIT).
  - in_valid and flush in the same cycle → that symbol is included.
- **Normalisation**: 2000 random symbols with bm slices all 7 except a random one at 0.
  - Required: no metric wrap, every out matches a reference model, and some pm is 0 each step.
- **Tie handling**: all bm slices equal (e.g. 5).
  - Required: all states' metrics stay 0, decisions pick b=0, decoded bits all 0, and error=0 after TB symbols.
- **Async reset**: assert reset mid-FLUSH.
  - Required: out_valid drops immediately, and after release in_ready=1, fill=0, the first output appears after TB symbols.
